// File: rtl/signext_mc_ctrl_pkg.sv
// Shared constants for the multicycle controller: opcodes, FSM state encoding,
// and the alu_op / alu_src_b / pc_src field encodings.
package signext_mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_IMMEXEC = 4'd9,
    S_IMMWB   = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_logic_imm(input logic [5:0] opc);
    return (opc == OP_ANDI) || (opc == OP_ORI);
  endfunction

endpackage

// File: rtl/signext_mc_ctrl.sv
// Moore controller for a multicycle MIPS-style datapath with a sign/zero extender.
// Optional macro LOGIC_IMM_EN adds andi/ori (zero-extended, logic ALU op) decode.
module signext_mc_ctrl
  import signext_mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       ext_op,
  output logic       illegal,
  output logic [3:0] state
);

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= S_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef LOGIC_IMM_EN
  // IMMEXEC must not look at op, so the andi/ori flavour is captured in DECODE.
  logic limm_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      limm_reg <= 1'b0;
    end else if (state_reg == S_DECODE) begin
      limm_reg <= is_logic_imm(op);
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:   if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_ADDI:      state_next = S_IMMEXEC;
`ifdef LOGIC_IMM_EN
          OP_ANDI, OP_ORI: state_next = S_IMMEXEC;
`endif
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (mem_ready) state_next = S_MEMWB;
      S_MEMWR:   if (mem_ready) state_next = S_FETCH;
      S_MEMWB:   state_next = S_FETCH;
      S_EXEC:    state_next = S_ALUWB;
      S_ALUWB:   state_next = S_FETCH;
      S_BRANCH:  state_next = S_FETCH;
      S_IMMEXEC: state_next = S_IMMWB;
      S_IMMWB:   state_next = S_FETCH;
      S_JUMP:    state_next = S_FETCH;
      S_ILLEGAL: state_next = S_FETCH;
      default:   state_next = S_FETCH;
    endcase
  end

  // Outputs depend on state only; the FETCH write enables are the sole mem_ready terms.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_src        = PC_ALU;
    ext_op        = 1'b1;
    illegal       = 1'b0;
    case (state_reg)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:  alu_src_b = SRCB_IMM_SH2;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
      end
      S_IMMEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
`ifdef LOGIC_IMM_EN
        if (limm_reg) begin
          ext_op = 1'b0;
          alu_op = ALU_LOGIC;
        end
`endif
      end
      S_IMMWB:   reg_write = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_JUMP;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
  end

  assign state = state_reg;

endmodule

// File: tb/tb_signext_mc_ctrl.sv
// Directed bench for signext_mc_ctrl: per-cycle comparison against a table model
// of the instruction flows, plus literal spot checks on logged observations.
module tb_signext_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] op = 6'b000000;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, ext_op, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic [3:0] state;

  signext_mc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_src(pc_src), .ext_op(ext_op), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] FE = 4'd0, DE = 4'd1, MA = 4'd2, MR = 4'd3, MB = 4'd4,
                         MW = 4'd5, EX = 4'd6, AW = 4'd7, BR = 4'd8, IE = 4'd9,
                         IW = 4'd10, JP = 4'd11, IL = 4'd12;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       ext_op, illegal;
  } ctrl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       reg_write, mem_write, mem_read, illegal, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_op;
    logic       ext_op;
  } obs_t;

  int         checks = 0;
  int         errors = 0;
  int         cycle = 0;
  logic       chk_en = 1'b0;
  logic [3:0] exp_state = FE;
  logic       exp_limm = 1'b0;
  obs_t       log_q[$];

  // Control word each state must present, straight from the state table.
  function automatic ctrl_t model(input logic [3:0] st, input logic mr, input logic limm);
    ctrl_t e;
    e = '0;
    e.ext_op = 1'b1;
    if (st == FE) begin
      e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr;
    end
    if (st == DE) e.alu_src_b = 2'b11;
    if (st == MA) begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
    if (st == MR) begin e.mem_read = 1'b1; e.iord = 1'b1; end
    if (st == MW) begin e.mem_write = 1'b1; e.iord = 1'b1; end
    if (st == MB) begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
    if (st == EX) begin e.alu_src_a = 1'b1; e.alu_op = 2'b10; end
    if (st == AW) begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
    if (st == BR) begin
      e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1; e.pc_src = 2'b01;
    end
    if (st == IE) begin
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      if (limm) begin e.ext_op = 1'b0; e.alu_op = 2'b11; end
    end
    if (st == IW) e.reg_write = 1'b1;
    if (st == JP) begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
    if (st == IL) e.illegal = 1'b1;
    return e;
  endfunction

  always @(negedge clk) begin
    ctrl_t act, expv;
    if (chk_en) begin
      act = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst,
             mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, ext_op, illegal};
      expv = model(exp_state, mem_ready, exp_limm);
      checks++;
      if (state !== exp_state) begin
        errors++;
        $display("FAIL state cycle %0d: got %0d expected %0d", cycle, state, exp_state);
      end
      checks++;
      if (act !== expv) begin
        errors++;
        $display("FAIL ctrl cycle %0d state %0d: got %h expected %h", cycle, exp_state, act, expv);
      end
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic step(input logic [3:0] st, input logic mr, input logic [5:0] o, input logic r);
    obs_t ob;
    @(posedge clk);
    #1;
    cycle++;
    exp_state = st;
    mem_ready = mr;
    op = o;
    rst_n = r;
    chk_en = 1'b1;
    #3;
    ob = '{state, reg_write, mem_write, mem_read, illegal, pc_write, pc_write_cond,
           pc_src, alu_op, ext_op};
    log_q.push_back(ob);
  endtask

  // One instruction: fw fetch wait cycles, mw memory wait cycles; op is noise outside DECODE/MEMADR.
  task automatic run(input logic [5:0] o, input int fw, input int mw);
    logic [5:0] nz;
    int         start;
    nz = o ^ 6'b111111;
    start = log_q.size();
`ifdef LOGIC_IMM_EN
    exp_limm = (o == 6'b001100) || (o == 6'b001101);
`else
    exp_limm = 1'b0;
`endif
    for (int i = 0; i < fw; i++) step(FE, 1'b0, nz, 1'b1);
    step(FE, 1'b1, nz, 1'b1);
    step(DE, 1'b1, o, 1'b1);
    case (o)
      6'b100011: begin
        step(MA, 1'b1, o, 1'b1);
        for (int i = 0; i < mw; i++) step(MR, 1'b0, nz, 1'b1);
        step(MR, 1'b1, nz, 1'b1);
        step(MB, 1'b1, nz, 1'b1);
      end
      6'b101011: begin
        step(MA, 1'b1, o, 1'b1);
        for (int i = 0; i < mw; i++) step(MW, 1'b0, nz, 1'b1);
        step(MW, 1'b1, nz, 1'b1);
      end
      6'b000000: begin step(EX, 1'b1, nz, 1'b1); step(AW, 1'b1, nz, 1'b1); end
      6'b000100: step(BR, 1'b1, nz, 1'b1);
      6'b001000: begin step(IE, 1'b1, nz, 1'b1); step(IW, 1'b1, nz, 1'b1); end
`ifdef LOGIC_IMM_EN
      6'b001100, 6'b001101: begin step(IE, 1'b1, nz, 1'b1); step(IW, 1'b1, nz, 1'b1); end
`endif
      6'b000010: step(JP, 1'b1, nz, 1'b1);
      default:   step(IL, 1'b1, nz, 1'b1);
    endcase
    $display("txn op=%b fetch_wait=%0d mem_wait=%0d cycles=%0d", o, fw, mw, log_q.size() - start);
  endtask

  function automatic int count_rw();
    int n = 0;
    foreach (log_q[i]) n += int'(log_q[i].reg_write);
    return n;
  endfunction

  function automatic int count_mw();
    int n = 0;
    foreach (log_q[i]) n += int'(log_q[i].mem_write);
    return n;
  endfunction

  function automatic int count_ill();
    int n = 0;
    foreach (log_q[i]) n += int'(log_q[i].illegal);
    return n;
  endfunction

  function automatic int find_state(input logic [3:0] st);
    foreach (log_q[i]) if (log_q[i].st == st) return i;
    return 0;
  endfunction

  initial begin
    int k;
    // Power-up reset
    step(FE, 1'b0, 6'b000000, 1'b0);
    step(FE, 1'b0, 6'b000000, 1'b0);
    chk("reset_state", int'(log_q[0].st), 0);
    chk("reset_mem_read", int'(log_q[0].mem_read), 1);
    chk("reset_pc_write", int'(log_q[0].pc_write), 0);
    step(FE, 1'b0, 6'b000000, 1'b1);
    $display("txn reset cycles=3");

    // lw, no waits: 5 cycles, reg_write only in the last one
    log_q.delete();
    run(6'b100011, 0, 0);
    chk("lw_cycles", log_q.size(), 5);
    chk("lw_state3", int'(log_q[3].st), 3);
    chk("lw_rw_count", count_rw(), 1);
    chk("lw_rw_cycle5", int'(log_q[4].reg_write), 1);

    // sw with 3 memory wait cycles
    log_q.delete();
    run(6'b101011, 0, 3);
    chk("sw_mem_write_cycles", count_mw(), 4);
    chk("sw_cycles", log_q.size(), 7);

    // R-type with fetch waits, lw with memory waits
    log_q.delete();
    run(6'b000000, 2, 0);
    chk("rtype_cycles", log_q.size(), 6);
    run(6'b100011, 1, 2);

    // addi keeps sign-extension and add
    log_q.delete();
    run(6'b001000, 0, 0);
    k = find_state(IE);
    chk("addi_ext_op", int'(log_q[k].ext_op), 1);
    chk("addi_alu_op", int'(log_q[k].alu_op), 0);

    // ori: logic-immediate when enabled, illegal otherwise
    log_q.delete();
    run(6'b001101, 0, 0);
`ifdef LOGIC_IMM_EN
    k = find_state(IE);
    chk("ori_ext_op", int'(log_q[k].ext_op), 0);
    chk("ori_alu_op", int'(log_q[k].alu_op), 3);
`else
    chk("ori_illegal", count_ill(), 1);
`endif
    log_q.delete();
    run(6'b001100, 0, 0);
`ifdef LOGIC_IMM_EN
    chk("andi_reg_write", count_rw(), 1);
`else
    chk("andi_illegal", count_ill(), 1);
`endif

    // Illegal opcode
    log_q.delete();
    run(6'b111111, 0, 0);
    chk("ill_pulse", count_ill(), 1);
    chk("ill_reg_write", count_rw(), 0);
    chk("ill_mem_write", count_mw(), 0);
    chk("ill_cycles", log_q.size(), 3);

    // beq then j
    log_q.delete();
    run(6'b000100, 0, 0);
    run(6'b000010, 0, 0);
    chk("beq_pwc", int'(log_q[2].pc_write_cond), 1);
    chk("beq_pc_src", int'(log_q[2].pc_src), 1);
    chk("j_pc_write", int'(log_q[5].pc_write), 1);
    chk("j_pc_src", int'(log_q[5].pc_src), 2);

    // Reset held for 2 cycles while waiting in MEMRD
    log_q.delete();
    exp_limm = 1'b0;
    step(FE, 1'b1, 6'b000000, 1'b1);
    step(DE, 1'b1, 6'b100011, 1'b1);
    step(MA, 1'b1, 6'b100011, 1'b1);
    step(MR, 1'b0, 6'b000000, 1'b1);
    step(MR, 1'b1, 6'b000000, 1'b0);
    step(FE, 1'b1, 6'b000000, 1'b0);
    step(FE, 1'b0, 6'b000000, 1'b1);
    chk("rst_memrd_state", int'(log_q[6].st), 0);
    chk("rst_memrd_mem_read", int'(log_q[6].mem_read), 1);
    chk("rst_memrd_rw", count_rw(), 0);
    $display("txn reset_in_memrd cycles=%0d", log_q.size());

    run(6'b101011, 0, 1);
    step(FE, 1'b0, 6'b000000, 1'b1);
    @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signext_mc_ctrl.md
SIGNEXT_MC_CTRL -- requirements
Module: signext_mc_ctrl

Interface
REQ-001 The block SHALL have no parameters; opcode and state encodings are fixed constants.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset, active-low, sampled on rising clk only.
REQ-005 op  input  6  instruction[31:26] from the instruction register.
REQ-006 mem_ready  input  1  memory has completed the current access this cycle.
REQ-007 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a  output  1 each  multicycle datapath controls.
REQ-008 alu_src_b  output  2  00 reg B, 01 const 4, 10 extended imm, 11 extended imm<<2.
REQ-009 alu_op  output  2  00 add, 01 sub, 10 funct-decode, 11 logic-imm.
REQ-010 pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 ext_op  output  1  extender mode to the signext unit: 1 sign-extend imm[15:0], 0 zero-extend.
REQ-012 illegal  output  1  one-cycle pulse on an unsupported opcode.
REQ-013 state  output  4  current FSM state, for debug.

Function
REQ-014 Moore FSM; all outputs SHALL decode from the state register only, except the mem_ready qualifications given below.
REQ-015 States SHALL be: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IMMEXEC, IMMWB, JUMP, ILLEGAL.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
REQ-017 FETCH: ir_write and pc_write SHALL equal mem_ready; the FSM stays in FETCH while mem_ready=0 and moves to DECODE on mem_ready=1.
REQ-018 DECODE: alu_src_b=11, ext_op=1, alu_op=00.
REQ-019 DECODE next state: 100011/101011 go to MEMADR; 000000 goes to EXEC; 000100 goes to BRANCH; 001000 goes to IMMEXEC; 000010 goes to JUMP; anything else goes to ILLEGAL.
REQ-020 MEMADR: alu_src_a=1, alu_src_b=10, ext_op=1; next state is MEMRD for lw and MEMWR for sw.
REQ-021 MEMRD: mem_read=1, iord=1; waits for mem_ready=1, then goes to MEMWB.
REQ-022 MEMWR: mem_write=1, iord=1; waits for mem_ready=1, then goes to FETCH; mem_write SHALL remain high across all wait cycles.
REQ-023 MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; next state is FETCH.
REQ-024 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next state is ALUWB.
REQ-025 ALUWB: reg_write=1, reg_dst=1; next state is FETCH.
REQ-026 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01; next state is FETCH.
REQ-027 IMMEXEC: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=00; next state is IMMWB.
REQ-028 IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0; next state is FETCH.
REQ-029 JUMP: pc_write=1, pc_src=10; next state is FETCH.
REQ-030 ILLEGAL: illegal=1 for exactly one cycle, no writes asserted; next state is FETCH.
REQ-031 In every state not listed above as asserting a control, that control SHALL be 0, and ext_op SHALL default to 1.
REQ-032 op SHALL be sampled only in DECODE and MEMADR; op changes in other states have no effect.
REQ-033 Cycle counts with mem_ready held at 1 SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-034 rst_n=0 at a rising edge SHALL force state to FETCH, overriding any transition, including mid-wait in MEMRD or MEMWR.
REQ-035 While state=FETCH after reset, outputs SHALL be the FETCH values, and no write enable other than the FETCH enables qualified by mem_ready SHALL be active.

Configuration
REQ-036 Macro LOGIC_IMM_EN, when defined, SHALL add decode of andi (001100) and ori (001101) to IMMEXEC.
REQ-037 With LOGIC_IMM_EN defined, IMMEXEC SHALL drive ext_op=0 and alu_op=11 for andi/ori, while addi keeps ext_op=1 and alu_op=00.
REQ-038 Without LOGIC_IMM_EN, opcodes 001100 and 001101 SHALL go to ILLEGAL.

Structure
REQ-039 A shared package SHALL hold the opcode constants, the state encoding, and the alu_op/alu_src_b/pc_src encodings.
REQ-040 The block SHALL have no sub-modules, but SHALL keep the next-state logic and the output decode as separate always blocks.

Verification
REQ-041 Reset: rst_n=0 for 2 cycles while in MEMRD -> state=FETCH and mem_read=1 on the first cycle after release.
REQ-042 lw: op=100011, mem_ready=1 -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB, with reg_write=1 only in cycle 5.
REQ-043 sw with 3 wait cycles: mem_ready=0 for 3 cycles in MEMWR -> mem_write=1 for 4 cycles, then FETCH.
REQ-044 Immediate 16'hFFFE: addi in IMMEXEC gives ext_op=1; with LOGIC_IMM_EN, ori gives ext_op=0, alu_op=11.
REQ-045 Illegal op 111111 -> illegal=1 for exactly 1 cycle, reg_write=0 and mem_write=0 throughout, then back to FETCH.
REQ-046 beq then j -> pc_write_cond=1 and pc_src=01 in cycle 3, then pc_write=1 and pc_src=10 in cycle 6.
